// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with synchronous
// flush-to-bubble. SKID=0 is a single entry whose in_ready follows out_ready
// combinationally; SKID=1 adds a skid entry so in_ready comes from a flop.
module pipe_stage_reg #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                SKID       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // A squash cycle never accepts; a drain still completes from the
  // downstream view and downstream is expected to squash it itself.
  logic acc, drn;
  assign acc = in_valid & in_ready & ~flush;
  assign drn = out_valid & out_ready;

  if (SKID == 1'b0) begin : g_flat
    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = ~vld_q | out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    // Single entry: load on accept, clear valid on a drain with no refill.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= BUBBLE_VAL;
      end else if (flush) begin
        vld_q  <= 1'b0;
        data_q <= BUBBLE_VAL;
      end else if (acc) begin
        vld_q  <= 1'b1;
        data_q <= in_data;
      end else if (drn) begin
        vld_q  <= 1'b0;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] main_q, main_n;
    logic [DATA_W-1:0] skid_q, skid_n;
    logic              rdy_q;

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    // State and payload registers; in_ready is precomputed from next state
    // so the upstream never sees a combinational path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= BUBBLE_VAL;
        skid_q  <= BUBBLE_VAL;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_n;
        main_q  <= main_n;
        skid_q  <= skid_n;
        rdy_q   <= (state_n != FULL);
      end
    end

    // Next-state: main always holds the oldest payload, skid the newer one.
    always_comb begin
      state_n = state_q;
      main_n  = main_q;
      skid_n  = skid_q;
      if (flush) begin
        state_n = EMPTY;
        main_n  = BUBBLE_VAL;
      end else begin
        case (state_q)
          EMPTY: begin
            if (acc) begin
              state_n = BUSY;
              main_n  = in_data;
            end
          end
          BUSY: begin
            if (acc && drn) begin
              main_n  = in_data;
            end else if (acc) begin
              state_n = FULL;
              skid_n  = in_data;
            end else if (drn) begin
              state_n = EMPTY;
            end
          end
          FULL: begin
            if (drn) begin
              state_n = BUSY;
              main_n  = skid_q;
            end
          end
          default: state_n = EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share the
// same stimulus; each is tracked by a FIFO reference model (depth 2 / 1).
module tb_pipe_stage_reg;
  localparam int         W    = 16;
  localparam logic [W-1:0] BUB1 = 16'h0000;
  localparam logic [W-1:0] BUB0 = 16'hBEEF;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         rdy1, vld1, rdy0, vld0;
  logic [W-1:0] dat1, dat0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUB1), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .out_valid(vld1), .out_data(dat1), .out_ready(out_ready)
  );

  pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUB0), .SKID(1'b0)) u_flat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .out_valid(vld0), .out_data(dat0), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference models: a plain FIFO per instance plus the last value shown.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] last1, last0;
  bit acc1, acc0, drn1, drn0;

  // Monitor: at the falling edge compare outputs to the model, then apply
  // the handshake the coming rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      q1.delete(); q0.delete();
      last1 = BUB1; last0 = BUB0;
    end else begin
      chkb("skid_valid", vld1, q1.size() > 0);
      chkb("skid_ready", rdy1, q1.size() < 2);
      chk ("skid_data",  dat1, (q1.size() > 0) ? q1[0] : last1);
      chkb("flat_valid", vld0, q0.size() > 0);
      chkb("flat_ready", rdy0, (q0.size() == 0) || out_ready);
      chk ("flat_data",  dat0, (q0.size() > 0) ? q0[0] : last0);

      acc1 = in_valid && (q1.size() < 2) && !flush;
      acc0 = in_valid && ((q0.size() == 0) || out_ready) && !flush;
      drn1 = (q1.size() > 0) && out_ready;
      drn0 = (q0.size() > 0) && out_ready;
      if (drn1) last1 = q1.pop_front();
      if (drn0) last0 = q0.pop_front();
      if (flush) begin
        q1.delete(); q0.delete();
        last1 = BUB1; last0 = BUB0;
      end else begin
        if (acc1) q1.push_back(in_data);
        if (acc0) q0.push_back(in_data);
      end
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  int seq = 0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chkb("rst_skid_valid", vld1, 1'b0);
    chk ("rst_skid_data",  dat1, BUB1);
    chkb("rst_skid_ready", rdy1, 1'b1);
    chk ("rst_flat_data",  dat0, BUB0);
    rst = 1'b0;

    // Streaming at full rate: 1-cycle latency, no gaps.
    step(1'b1, 16'h0010, 1'b1, 1'b0);
    chk("stream0_skid", dat1, 16'h0010); chk("stream0_flat", dat0, 16'h0010);
    step(1'b1, 16'h0011, 1'b1, 1'b0);
    chk("stream1_skid", dat1, 16'h0011); chkb("stream1_valid", vld1, 1'b1);
    step(1'b1, 16'h0012, 1'b1, 1'b0);
    chk("stream2_skid", dat1, 16'h0012); chk("stream2_flat", dat0, 16'h0012);

    // Async reset in the middle of a cycle with live payloads held.
    step(1'b1, 16'h0033, 1'b0, 1'b0);
    chkb("pre_rst_valid", vld1, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chkb("async_rst_skid_valid", vld1, 1'b0);
    chk ("async_rst_skid_data",  dat1, BUB1);
    chkb("async_rst_skid_ready", rdy1, 1'b1);
    chkb("async_rst_flat_valid", vld0, 1'b0);
    chk ("async_rst_flat_data",  dat0, BUB0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-pressure: skid takes B while flat stalls; C is refused by skid.
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0);
    chkb("bp_skid_full_ready", rdy1, 1'b0);
    chk ("bp_skid_hold", dat1, 16'h00A1);
    chkb("bp_flat_ready", rdy0, 1'b0);
    chk ("bp_flat_hold", dat0, 16'h00A1);
    step(1'b1, 16'h00C3, 1'b0, 1'b0);
    chk ("bp_skid_stable", dat1, 16'h00A1);
    step(1'b1, 16'h00C3, 1'b1, 1'b0);
    chk ("bp_skid_second", dat1, 16'h00B2);
    chkb("bp_skid_ready_back", rdy1, 1'b1);
    chk ("bp_flat_replace", dat0, 16'h00C3);
    chkb("bp_flat_no_bubble", vld0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chkb("drain_skid_valid", vld1, 1'b0);
    chk ("drain_skid_keep",  dat1, 16'h00B2);
    chk ("drain_flat_keep",  dat0, 16'h00C3);

    // Flush while FULL with a simultaneous offer.
    step(1'b1, 16'h00A1, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0);
    step(1'b1, 16'h00DD, 1'b0, 1'b1);
    chkb("flush_skid_valid", vld1, 1'b0);
    chk ("flush_skid_data",  dat1, BUB1);
    chkb("flush_skid_ready", rdy1, 1'b1);
    chkb("flush_flat_valid", vld0, 1'b0);
    chk ("flush_flat_data",  dat0, BUB0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chkb("post_flush_idle", vld1, 1'b0);

    // Random traffic, no flush; unique payloads expose loss/duplication.
    for (int i = 0; i < 10000; i++) begin
      seq++;
      step(1'($urandom_range(0, 1)), W'(seq), 1'($urandom_range(0, 1)), 1'b0);
    end
    // Random traffic with sparse flush pulses.
    for (int i = 0; i < 2000; i++) begin
      seq++;
      step(1'($urandom_range(0, 1)), W'(seq), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
